// File: rtl/fighter_action_fsm.sv
// fighter_action_fsm: per-character action sequencer, advanced once per video frame.
// Handshake note: there is no valid/ready pair here. frame_tick_i is a one-cycle
// strobe that commits a decision; move/attack inputs are sampled only on that
// strobe, while hit_i is latched on any cycle and consumed by the next strobe.
module fighter_action_fsm #(
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 560,
  parameter int X_INIT         = 100,
  parameter int STEP           = 2,
  parameter int FACE_INIT      = 1,
  parameter int WINDUP_FRAMES  = 4,
  parameter int ACTIVE_FRAMES  = 3,
  parameter int RECOVER_FRAMES = 6,
  parameter int HITSTUN_FRAMES = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic       move_l_i,
  input  logic       move_r_i,
  input  logic       attack_i,
  input  logic       hit_i,
  output logic [9:0] pos_x_o,
  output logic       facing_o,
  output logic [2:0] state_o,
  output logic [2:0] anim_idx_o,
  output logic       attack_active_o,
  output logic       attack_start_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK_L  = 3'd1,
    ST_WALK_R  = 3'd2,
    ST_WINDUP  = 3'd3,
    ST_ACTIVE  = 3'd4,
    ST_RECOVER = 3'd5,
    ST_HITSTUN = 3'd6
  } state_e;

  localparam logic [9:0] X_MIN_C   = 10'(X_MIN);
  localparam logic [9:0] X_MAX_C   = 10'(X_MAX);
  localparam logic [9:0] X_INIT_C  = 10'(X_INIT);
  localparam logic [9:0] STEP_C    = 10'(STEP);
  localparam logic [9:0] LEFT_LIM  = 10'(X_MIN + STEP);
  localparam logic [9:0] RIGHT_LIM = 10'(X_MAX - STEP);
  localparam logic       FACE_C    = 1'(FACE_INIT);
  localparam logic [3:0] WINDUP_C  = 4'(WINDUP_FRAMES - 1);
  localparam logic [3:0] ACTIVE_C  = 4'(ACTIVE_FRAMES - 1);
  localparam logic [3:0] RECOVER_C = 4'(RECOVER_FRAMES - 1);
  localparam logic [3:0] HITSTUN_C = 4'(HITSTUN_FRAMES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] pos_q, pos_d;
  logic       face_q, face_d;
  logic [2:0] anim_q, anim_d;
  logic       act_q, act_d;
  logic       start_q, start_d;
  logic       prev_q, prev_d;
  logic       hp_q, hp_d;

  logic hit_now;
  logic atk_edge;
  logic timed;

  assign hit_now  = hp_q | hit_i;
  assign atk_edge = attack_i & ~prev_q;
  assign timed    = state_q inside {ST_WINDUP, ST_ACTIVE, ST_RECOVER, ST_HITSTUN};

  // Next-state, position, counter and registered-output decisions for one frame tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    face_d  = face_q;
    anim_d  = anim_q;
    act_d   = act_q;
    start_d = 1'b0;
    prev_d  = prev_q;
    hp_d    = hp_q | hit_i;
    if (frame_tick_i) begin
      prev_d = attack_i;
      hp_d   = 1'b0;
      if (hit_now) begin
        state_d = ST_HITSTUN;
        cnt_d   = HITSTUN_C;
      end else if (timed) begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          unique case (state_q)
            ST_WINDUP: begin
              state_d = ST_ACTIVE;
              cnt_d   = ACTIVE_C;
            end
            ST_ACTIVE: begin
              state_d = ST_RECOVER;
              cnt_d   = RECOVER_C;
            end
            default: begin
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end
          endcase
        end
      end else if (atk_edge) begin
        state_d = ST_WINDUP;
        cnt_d   = WINDUP_C;
        start_d = 1'b1;
      end else if (move_l_i && !move_r_i) begin
        state_d = ST_WALK_L;
        face_d  = 1'b0;
        pos_d   = (pos_q < LEFT_LIM) ? X_MIN_C : pos_q - STEP_C;
      end else if (move_r_i && !move_l_i) begin
        state_d = ST_WALK_R;
        face_d  = 1'b1;
        pos_d   = (pos_q > RIGHT_LIM) ? X_MAX_C : pos_q + STEP_C;
      end else begin
        state_d = ST_IDLE;
      end
      // A hit always restarts the animation, even when it re-enters HITSTUN.
      anim_d = ((state_d != state_q) || hit_now) ? 3'd0 : anim_q + 3'd1;
      act_d  = (state_d == ST_ACTIVE);
    end
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      pos_q   <= X_INIT_C;
      face_q  <= FACE_C;
      anim_q  <= 3'd0;
      act_q   <= 1'b0;
      start_q <= 1'b0;
      prev_q  <= 1'b1;
      hp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      face_q  <= face_d;
      anim_q  <= anim_d;
      act_q   <= act_d;
      start_q <= start_d;
      prev_q  <= prev_d;
      hp_q    <= hp_d;
    end
  end

  assign pos_x_o         = pos_q;
  assign facing_o        = face_q;
  assign state_o         = state_q;
  assign anim_idx_o      = anim_q;
  assign attack_active_o = act_q;
  assign attack_start_o  = start_q;

endmodule

// File: tb/tb_fighter_action_fsm.sv
// tb_fighter_action_fsm: directed and randomized frames against a frame-level model.
module tb_fighter_action_fsm;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, tick = 1'b0, ml = 1'b0, mr = 1'b0, atk = 1'b0, hit = 1'b0;

  logic [9:0] pos_x, pos_b;
  logic       facing, facing_b;
  logic [2:0] state, state_b, anim, anim_b;
  logic       act, act_b, start, start_b;

  fighter_action_fsm dut (
    .clk_i(clk), .rst_i(rst), .frame_tick_i(tick), .move_l_i(ml), .move_r_i(mr),
    .attack_i(atk), .hit_i(hit), .pos_x_o(pos_x), .facing_o(facing), .state_o(state),
    .anim_idx_o(anim), .attack_active_o(act), .attack_start_o(start)
  );

  fighter_action_fsm #(.X_INIT(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .frame_tick_i(tick), .move_l_i(ml), .move_r_i(mr),
    .attack_i(atk), .hit_i(hit), .pos_x_o(pos_b), .facing_o(facing_b), .state_o(state_b),
    .anim_idx_o(anim_b), .attack_active_o(act_b), .attack_start_o(start_b)
  );

  // ---------------- reference model (frame level) ----------------
  // Tracks elapsed frames in the current state instead of a down-counter.
  int m_pos, m_face, m_state, m_el, m_act, m_start;
  bit m_prev, m_hp;
  int dur    [7] = '{0, 0, 0, 4, 3, 6, 10};
  int follow [7] = '{0, 1, 2, 4, 5, 0, 0};

  task automatic model_reset();
    m_pos = 100; m_face = 1; m_state = 0; m_el = 0; m_act = 0; m_start = 0;
    m_prev = 1'b1; m_hp = 1'b0;
  endtask

  task automatic model_step(input logic t, input logic l, input logic r,
                            input logic a, input logic h);
    int ns, ne;
    bit hp, edge_seen;
    m_start = 0;
    if (!t) begin
      m_hp = m_hp | h;
      return;
    end
    hp = m_hp | h;
    edge_seen = a && !m_prev;
    ns = m_state;
    ne = 0;
    if (hp) begin
      ns = 6;
    end else if (m_state >= 3) begin
      if (m_el < dur[m_state] - 1) ne = m_el + 1;
      else ns = follow[m_state];
    end else if (edge_seen) begin
      ns = 3;
      m_start = 1;
    end else begin
      if (l && !r) begin
        ns = 1; m_face = 0;
        m_pos = (m_pos - 2 < 0) ? 0 : m_pos - 2;
      end else if (r && !l) begin
        ns = 2; m_face = 1;
        m_pos = (m_pos + 2 > 560) ? 560 : m_pos + 2;
      end else begin
        ns = 0;
      end
      ne = (ns == m_state) ? m_el + 1 : 0;
    end
    m_act = (ns == 4) ? 1 : 0;
    m_state = ns;
    m_el = ne;
    m_prev = a;
    m_hp = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pos_x", int'(pos_x), m_pos);
    chk("facing", int'(facing), m_face);
    chk("state", int'(state), m_state);
    chk("anim_idx", int'(anim), m_el % 8);
    chk("attack_active", int'(act), m_act);
    chk("attack_start", int'(start), m_start);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic t, input logic l, input logic r,
                     input logic a, input logic h);
    tick = t; ml = l; mr = r; atk = a; hit = h;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(t, l, r, a, h);
    #1;
    check_all();
  endtask

  // Gap cycles carry junk move/attack levels that must be ignored; hit_gap lands mid-frame.
  task automatic frame(input logic l, input logic r, input logic a,
                       input logic hit_gap, input logic hit_tick);
    int gap;
    gap = $urandom_range(1, 3);
    for (int i = 0; i < gap; i++)
      cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), (i == gap - 1) ? hit_gap : 1'b0);
    cyc(1'b1, l, r, a, hit_tick);
  endtask

  task automatic do_reset(input int n, input logic a);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom), 1'($urandom), a, 1'($urandom));
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  int p0, cnt_act, stun;
  int exp_b [3] = '{1, 0, 0};

  initial begin
    model_reset();
    do_reset(3, 1'b1);
    chk("rst_state", int'(state), 0);
    chk("rst_pos", int'(pos_x), 100);
    chk("rst_start", int'(start), 0);

    // Attack held through reset must not fire.
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("held_atk_state", int'(state), 0);
    chk("held_atk_pos", int'(pos_x), 100);

    // Left clamp on the X_INIT=3 instance.
    for (int i = 0; i < 3; i++) begin
      frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("clamp_l_pos", int'(pos_b), exp_b[i]);
      chk("clamp_l_face", int'(facing_b), 0);
    end

    // Release then press: attack with move_l held throughout.
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("windup_state", int'(state), 3);
    chk("windup_start", int'(start), 1);
    p0 = int'(pos_x);
    cnt_act = 0;
    for (int i = 0; i < 13; i++) begin
      frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      if (act) cnt_act++;
    end
    chk("active_frames", cnt_act, 3);
    chk("after_atk_state", int'(state), 0);
    chk("after_atk_pos", int'(pos_x), p0);
    frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("walk_after_atk_state", int'(state), 1);
    chk("walk_after_atk_pos", int'(pos_x), p0 - 2);

    // Right walk from 100 to the clamp.
    do_reset(1, 1'b0);
    for (int i = 0; i < 240; i++) begin
      frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 228) chk("walk_r_229", int'(pos_x), 558);
      if (i == 229) chk("walk_r_230", int'(pos_x), 560);
    end
    chk("walk_r_end_pos", int'(pos_x), 560);
    chk("walk_r_end_state", int'(state), 2);
    chk("walk_r_end_face", int'(facing), 1);

    // Both directions held: idle with counting animation.
    for (int i = 0; i < 5; i++) begin
      frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("both_anim", int'(anim), i);
    end
    chk("both_pos", int'(pos_x), 560);

    // Attack into ACTIVE, hit during ACTIVE frame 2, restart at stun tick 5.
    frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("active_f2_state", int'(state), 4);
    chk("active_f2_anim", int'(anim), 1);
    stun = 0;
    frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hit_drop_active", int'(act), 0);
    if (state == 3'd6) stun++;
    for (int i = 0; i < 4; i++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (state == 3'd6) stun++;
    end
    frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("restart_anim", int'(anim), 0);
    if (state == 3'd6) stun++;
    for (int i = 0; i < 10; i++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (state == 3'd6) stun++;
    end
    chk("stun_len", stun, 15);
    chk("stun_end_state", int'(state), 0);

    // Hit coincident with the tick while walking right.
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    p0 = int'(pos_x);
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("tick_hit_state", int'(state), 6);
    chk("tick_hit_pos", int'(pos_x), p0);

    // Reset during WINDUP with a hit pending.
    for (int i = 0; i < 10; i++) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_windup", int'(state), 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset(1, 1'b0);
    chk("mid_rst_pos", int'(pos_x), 100);
    chk("mid_rst_act", int'(act), 0);
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pending_cleared", int'(state), 0);

    // Randomized frames.
    for (int i = 0; i < 300; i++)
      frame(1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
